// File: rtl/serial_fifo_pkg.sv
// Shared definitions for the serial receive FIFO: upstream handshake state
// encoding and the default depth.
// Optional feature macro used by this slice: SERIAL_RX_FIFO_OVERRUN_CNT_EN.
package serial_fifo_pkg;

    // Default FIFO depth is 2**DEFAULT_DEPTH_LOG2 bytes.
    localparam int DEFAULT_DEPTH_LOG2 = 4;

    // Upstream (serial_port side) handshake states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK      = 2'd1,
        ST_WAIT_REL = 2'd2
    } rx_state_e;

endpackage : serial_fifo_pkg

// File: rtl/serial_rx_fifo_ram.sv
// fifo_ram: byte-wide storage for serial_rx_fifo with one synchronous write
// port and one asynchronous read port (first-word fall-through head byte).
module fifo_ram
    import serial_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [7:0]            wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [7:0]            rdata
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [7:0] mem [DEPTH];

    // Write the incoming byte at the tail address.
    // NOTE: storage has no reset; occupancy is tracked by the pointers and
    // count, so clearing the array would only cost logic and routing.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : fifo_ram

// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: captures bytes from serial_port through a req/ack
// handshake and buffers them for the memory controller.
// Optional feature: define SERIAL_RX_FIFO_OVERRUN_CNT_EN to drop (and count)
// bytes arriving while full; otherwise a full FIFO backpressures the sender.
module serial_rx_fifo
    import serial_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            com_data_in,
    input  logic                  com_int_req,
    output logic                  com_int_ack,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  rd_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic [7:0]            overrun_cnt
);

    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    rx_state_e             state;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  full;
    logic                  take;
    logic                  push;
    logic                  pop;

    // Full is judged on the occupancy at the start of the cycle, so a pop in
    // the same cycle does not make room for a push until the next cycle.
    assign full     = (count == FULL_COUNT);
    assign rd_ready = (count != '0);
    assign pop      = rd_en && rd_ready;
    assign push     = take && !full;

`ifdef SERIAL_RX_FIFO_OVERRUN_CNT_EN
    // Every request seen in IDLE is acknowledged; a full FIFO drops the byte.
    assign take = (state == ST_IDLE) && com_int_req;
`else
    // A full FIFO holds the request off until space appears.
    assign take = (state == ST_IDLE) && com_int_req && !full;
`endif

    // Upstream handshake: accept in IDLE, one registered ack cycle, then
    // wait for the request to drop so a byte is never captured twice.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            com_int_ack <= 1'b0;
        end else begin
            com_int_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        state       <= ST_ACK;
                        com_int_ack <= 1'b1;
                    end
                end
                ST_ACK: begin
                    state <= ST_WAIT_REL;
                end
                ST_WAIT_REL: begin
                    if (!com_int_req) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo the depth.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef SERIAL_RX_FIFO_OVERRUN_CNT_EN
    logic [7:0] overrun_q;

    // Count bytes dropped because the FIFO was full, saturating at 255.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overrun_q <= 8'd0;
        end else if (take && full && (overrun_q != 8'hFF)) begin
            overrun_q <= overrun_q + 8'd1;
        end
    end

    assign overrun_cnt = overrun_q;
`else
    assign overrun_cnt = 8'd0;
`endif

    fifo_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (com_data_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule : serial_rx_fifo

// File: tb/tb_serial_rx_fifo.sv
// Directed self-checking bench for serial_rx_fifo at DEPTH_LOG2 = 2.
// Follows SERIAL_RX_FIFO_OVERRUN_CNT_EN to pick the full-FIFO scenario.
module tb_serial_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] com_data_in;
    logic       com_int_req;
    logic       com_int_ack;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_ready;
    logic [2:0] count;
    logic [7:0] overrun_cnt;

    int checks    = 0;
    int errors    = 0;
    int ack_total = 0;

    always #5 clk = ~clk;

    serial_rx_fifo #(
        .DEPTH_LOG2 (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .com_data_in (com_data_in),
        .com_int_req (com_int_req),
        .com_int_ack (com_int_ack),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .count       (count),
        .overrun_cnt (overrun_cnt)
    );

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Full handshake for one byte, bounded wait for the ack.
    task automatic send_byte(input logic [7:0] d);
        int n;
        com_data_in = d;
        com_int_req = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (com_int_ack !== 1'b1 && n < 8);
        check("send_ack", 32'(com_int_ack), 32'd1);
        if (com_int_ack === 1'b1) ack_total++;
        com_int_req = 1'b0;
        tick();
        tick();
    endtask

    // Check the head byte, then pop it.
    task automatic pop_byte(input logic [7:0] exp);
        check("pop_ready", 32'(rd_ready), 32'd1);
        check("pop_data", 32'(rd_data), 32'(exp));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        com_data_in = 8'h00;
        com_int_req = 1'b0;
        rd_en       = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_ack", 32'(com_int_ack), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ready", 32'(rd_ready), 32'd0);
        check("rst_overrun", 32'(overrun_cnt), 32'd0);

        // Single byte 0x41
        rst = 1'b1;
        tick();
        com_data_in = 8'h41;
        com_int_req = 1'b1;
        tick();
        check("single_ack_hi", 32'(com_int_ack), 32'd1);
        check("single_ready", 32'(rd_ready), 32'd1);
        check("single_data", 32'(rd_data), 32'h41);
        check("single_count", 32'(count), 32'd1);
        com_int_req = 1'b0;
        tick();
        check("single_ack_lo", 32'(com_int_ack), 32'd0);
        tick();
        check("single_ack_lo2", 32'(com_int_ack), 32'd0);
        pop_byte(8'h41);
        check("single_empty", 32'(count), 32'd0);
        check("single_ready_lo", 32'(rd_ready), 32'd0);

        // Fill and wrap
        for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i));
        check("fill_count", 32'(count), 32'd4);
        pop_byte(8'h10);
        pop_byte(8'h11);
        check("wrap_count2", 32'(count), 32'd2);
        send_byte(8'h14);
        send_byte(8'h15);
        check("wrap_full", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) pop_byte(8'(8'h12 + i));
        check("wrap_empty", 32'(count), 32'd0);

`ifdef SERIAL_RX_FIFO_OVERRUN_CNT_EN
        // Overrun: fifth byte acknowledged but dropped
        ack_total = 0;
        for (int i = 0; i < 5; i++) send_byte(8'(i));
        check("ovr_acks", 32'(ack_total), 32'd5);
        check("ovr_cnt", 32'(overrun_cnt), 32'd1);
        check("ovr_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) pop_byte(8'(i));
        check("ovr_empty", 32'(count), 32'd0);
        check("ovr_ready_lo", 32'(rd_ready), 32'd0);
`else
        // Backpressure: request held while full gets no ack
        for (int i = 0; i < 4; i++) send_byte(8'(i));
        com_data_in = 8'h04;
        com_int_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_no_ack", 32'(com_int_ack), 32'd0);
            check("bp_full", 32'(count), 32'd4);
        end
        check("bp_head", 32'(rd_data), 32'h00);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("bp_pop_no_ack", 32'(com_int_ack), 32'd0);
        check("bp_pop_count", 32'(count), 32'd3);
        tick();
        check("bp_ack", 32'(com_int_ack), 32'd1);
        check("bp_refill", 32'(count), 32'd4);
        com_int_req = 1'b0;
        tick();
        tick();
        for (int i = 1; i < 5; i++) pop_byte(8'(i));
        check("bp_empty", 32'(count), 32'd0);
        check("bp_overrun_zero", 32'(overrun_cnt), 32'd0);
`endif

        // Held request: one byte despite 10 extra cycles of req
        com_data_in = 8'h77;
        com_int_req = 1'b1;
        tick();
        check("held_ack", 32'(com_int_ack), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("held_no_ack", 32'(com_int_ack), 32'd0);
        end
        check("held_count", 32'(count), 32'd1);
        com_int_req = 1'b0;
        tick();
        tick();
        check("held_count2", 32'(count), 32'd1);
        pop_byte(8'h77);
        check("held_empty", 32'(count), 32'd0);

        // Reset during ACK, request still high afterwards
        com_data_in = 8'h55;
        com_int_req = 1'b1;
        tick();
        check("mid_ack", 32'(com_int_ack), 32'd1);
        check("mid_count", 32'(count), 32'd1);
        rst = 1'b0;
        tick();
        check("mid_rst_ack", 32'(com_int_ack), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_ready", 32'(rd_ready), 32'd0);
        check("mid_rst_overrun", 32'(overrun_cnt), 32'd0);
        rst = 1'b1;
        com_data_in = 8'h66;
        tick();
        check("recap_ack", 32'(com_int_ack), 32'd1);
        check("recap_count", 32'(count), 32'd1);
        check("recap_data", 32'(rd_data), 32'h66);
        com_int_req = 1'b0;
        tick();
        tick();
        pop_byte(8'h66);

        // rd_en on empty is ignored
        rd_en = 1'b1;
        tick();
        tick();
        rd_en = 1'b0;
        check("empty_rd_count", 32'(count), 32'd0);
        check("empty_rd_ready", 32'(rd_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_rx_fifo
